// File: rtl/dot_result_join_if.sv
// Bundle between the dot-product core halves, the join stage and its accuracy monitor.
interface dot_result_join_if #(
    parameter int W_HALF = 9,
    parameter int W_SUM  = 10,
    parameter int W_ACC  = 20
);
    logic              en_out1;
    logic [W_HALF-1:0] result1;
    logic              en_out2;
    logic [W_HALF-1:0] result2;
    logic [W_SUM-1:0]  ideal;
    logic              sum_valid;
    logic [W_SUM-1:0]  sum;
    logic [W_SUM-1:0]  err;
    logic              next_req;
    logic              mae_valid;
    logic [W_ACC-1:0]  mae_sum;
    logic [9:0]        sample_cnt;
    logic              overrun;

    modport master (
        output en_out1, result1, en_out2, result2, ideal,
        input  sum_valid, sum, err, next_req, mae_valid, mae_sum, sample_cnt, overrun
    );

    modport slave (
        input  en_out1, result1, en_out2, result2, ideal,
        output sum_valid, sum, err, next_req, mae_valid, mae_sum, sample_cnt, overrun
    );
endinterface

// File: rtl/dot_result_join.sv
// Joins the two half-results of the dot-product core into one sum and accumulates
// absolute error against an ideal reference over a fixed sample window.
//
// state | meaning
// EMPTY | no half held
// HAVE1 | result1 held, waiting for result2
// HAVE2 | result2 held, waiting for result1
// JOIN  | sum/err presented this cycle, both slots free again
module dot_result_join #(
    parameter int W_HALF = 9,
    parameter int W_SUM  = 10,
    parameter int WINDOW = 1000,
    parameter int W_ACC  = 20
) (
    input logic              clk,
    input logic              rst,
    dot_result_join_if.slave bus
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HAVE1 = 2'd1;
    localparam logic [1:0] HAVE2 = 2'd2;
    localparam logic [1:0] JOIN  = 2'd3;
    localparam int W_ACC1 = W_ACC + 1;

    logic [1:0]        state, state_nxt;
    logic [W_HALF-1:0] slot1, slot2;
    logic              full1, full2, take1, take2, join_now;
    logic [W_HALF-1:0] val1, val2;
    logic [W_SUM-1:0]  sum_nxt, err_nxt;

    logic              sum_valid_q;
    logic [W_SUM-1:0]  sum_q, err_q;
    logic              overrun_q;
    logic [W_ACC-1:0]  acc, acc_sat, mae_sum_q;
    logic [W_ACC:0]    acc_add;
    logic [9:0]        cnt;
    logic [10:0]       cnt_inc;
    logic              mae_valid_q;

    always_comb begin
        full1    = (state == HAVE1);
        full2    = (state == HAVE2);
        take1    = bus.en_out1 && !full1;
        take2    = bus.en_out2 && !full2;
        join_now = (full1 || take1) && (full2 || take2);
        // A held half always wins over a duplicate arriving in the same cycle.
        val1     = full1 ? slot1 : bus.result1;
        val2     = full2 ? slot2 : bus.result2;
        sum_nxt  = W_SUM'(val1) + W_SUM'(val2);
        err_nxt  = (sum_nxt >= bus.ideal) ? (sum_nxt - bus.ideal) : (bus.ideal - sum_nxt);

        state_nxt = EMPTY;
        if (join_now)
            state_nxt = JOIN;
        else if (full1 || take1)
            state_nxt = HAVE1;
        else if (full2 || take2)
            state_nxt = HAVE2;

        acc_add = {1'b0, acc} + W_ACC1'(err_q);
        acc_sat = acc_add[W_ACC] ? '1 : acc_add[W_ACC-1:0];
        cnt_inc = {1'b0, cnt} + 11'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            slot1       <= '0;
            slot2       <= '0;
            sum_valid_q <= 1'b0;
            sum_q       <= '0;
            err_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            sum_valid_q <= join_now;
            if (take1)
                slot1 <= bus.result1;
            if (take2)
                slot2 <= bus.result2;
            if (join_now) begin
                sum_q <= sum_nxt;
                err_q <= err_nxt;
            end
            if ((bus.en_out1 && full1) || (bus.en_out2 && full2))
                overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            mae_sum_q   <= '0;
            mae_valid_q <= 1'b0;
        end else begin
            mae_valid_q <= 1'b0;
            if (sum_valid_q) begin
                if (cnt_inc == 11'(WINDOW)) begin
                    mae_sum_q   <= acc_sat;
                    mae_valid_q <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                end else begin
                    acc <= acc_sat;
                    cnt <= cnt_inc[9:0];
                end
            end
        end
    end

    assign bus.sum_valid  = sum_valid_q;
    assign bus.next_req   = sum_valid_q;
    assign bus.sum        = sum_q;
    assign bus.err        = err_q;
    assign bus.overrun    = overrun_q;
    assign bus.mae_valid  = mae_valid_q;
    assign bus.mae_sum    = mae_sum_q;
    assign bus.sample_cnt = cnt;
endmodule

// File: tb/tb_dot_result_join.sv
// Bench for dot_result_join: directed scenarios plus random traffic against a slot-level model.
module tb_dot_result_join;
    localparam int W_HALF = 9;
    localparam int W_SUM  = 10;
    localparam int WINDOW = 4;
    localparam int W_ACC  = 20;
    localparam longint ACC_MAX = (longint'(1) << W_ACC) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_result_join_if #(.W_HALF(W_HALF), .W_SUM(W_SUM), .W_ACC(W_ACC)) bus ();

    dot_result_join #(.W_HALF(W_HALF), .W_SUM(W_SUM), .WINDOW(WINDOW), .W_ACC(W_ACC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: two holding slots plus the list of errors in the open window.
    bit     m_full1, m_full2, m_ovr;
    int     m_v1, m_v2;
    bit     e_sv, e_mv;
    int     e_sum, e_err, e_cnt;
    longint e_mae;
    int     win_errs[$];

    task automatic set_in(input bit e1, input int r1, input bit e2, input int r2, input int id);
        bus.en_out1 = e1;
        bus.result1 = W_HALF'(r1);
        bus.en_out2 = e2;
        bus.result2 = W_HALF'(r2);
        bus.ideal   = W_SUM'(id);
    endtask

    task automatic tick();
        longint total;
        @(posedge clk);
        if (rst) begin
            m_full1 = 0; m_full2 = 0; m_ovr = 0; m_v1 = 0; m_v2 = 0;
            e_sv = 0; e_mv = 0; e_sum = 0; e_err = 0; e_cnt = 0; e_mae = 0;
            win_errs.delete();
        end else begin
            e_mv = 0;
            if (e_sv) begin
                win_errs.push_back(e_err);
                if (win_errs.size() == WINDOW) begin
                    total = 0;
                    foreach (win_errs[i]) total += win_errs[i];
                    e_mae = (total > ACC_MAX) ? ACC_MAX : total;
                    e_mv = 1;
                    win_errs.delete();
                end
            end
            e_cnt = win_errs.size();
            if (bus.en_out1) begin
                if (m_full1) m_ovr = 1;
                else begin m_full1 = 1; m_v1 = int'(bus.result1); end
            end
            if (bus.en_out2) begin
                if (m_full2) m_ovr = 1;
                else begin m_full2 = 1; m_v2 = int'(bus.result2); end
            end
            if (m_full1 && m_full2) begin
                e_sv  = 1;
                e_sum = m_v1 + m_v2;
                e_err = (e_sum > int'(bus.ideal)) ? e_sum - int'(bus.ideal) : int'(bus.ideal) - e_sum;
                m_full1 = 0;
                m_full2 = 0;
            end else begin
                e_sv = 0;
            end
        end
        #1;
    endtask

    task automatic do_sample(input int a, input int b, input int id);
        set_in(1, a, 1, b, id);
        tick();
        set_in(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0);
        rst = 1;
        tick();
        tick();
        rst = 0;
        vectors++; if (bus.sum_valid !== 1'b0) begin miscompares++; $display("FAIL reset sum_valid got %0b exp 0", bus.sum_valid); end
        vectors++; if (bus.next_req !== 1'b0) begin miscompares++; $display("FAIL reset next_req got %0b exp 0", bus.next_req); end
        vectors++; if (bus.sum !== '0) begin miscompares++; $display("FAIL reset sum got %0d exp 0", bus.sum); end
        vectors++; if (bus.err !== '0) begin miscompares++; $display("FAIL reset err got %0d exp 0", bus.err); end
        vectors++; if (bus.mae_valid !== 1'b0) begin miscompares++; $display("FAIL reset mae_valid got %0b exp 0", bus.mae_valid); end
        vectors++; if (bus.mae_sum !== '0) begin miscompares++; $display("FAIL reset mae_sum got %0d exp 0", bus.mae_sum); end
        vectors++; if (bus.sample_cnt !== '0) begin miscompares++; $display("FAIL reset sample_cnt got %0d exp 0", bus.sample_cnt); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL reset overrun got %0b exp 0", bus.overrun); end
    endtask

    task automatic test_both_same();
        set_in(1, 62, 1, 62, 124);
        tick();
        set_in(0, 0, 0, 0, 0);
        vectors++; if (bus.sum_valid !== 1'b1 || bus.next_req !== 1'b1) begin miscompares++; $display("FAIL same valid got %0b/%0b exp 1/1", bus.sum_valid, bus.next_req); end
        vectors++; if (bus.sum !== 10'd124) begin miscompares++; $display("FAIL same sum got %0d exp 124", bus.sum); end
        vectors++; if (bus.err !== 10'd0) begin miscompares++; $display("FAIL same err got %0d exp 0", bus.err); end
        tick();
        vectors++; if (bus.sum_valid !== 1'b0 || bus.next_req !== 1'b0) begin miscompares++; $display("FAIL same pulse_width got %0b/%0b exp 0/0", bus.sum_valid, bus.next_req); end
        vectors++; if (bus.sample_cnt !== 10'(e_cnt)) begin miscompares++; $display("FAIL same sample_cnt got %0d exp %0d", bus.sample_cnt, e_cnt); end
    endtask

    task automatic test_staggered();
        set_in(1, 40, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.sum_valid !== 1'b0) begin miscompares++; $display("FAIL stagger early_valid cyc %0d got %0b exp 0", i, bus.sum_valid); end
            if (i < 2) tick();
        end
        set_in(0, 0, 1, 25, 70);
        tick();
        set_in(0, 0, 0, 0, 0);
        vectors++; if (bus.sum_valid !== 1'b1) begin miscompares++; $display("FAIL stagger valid got %0b exp 1", bus.sum_valid); end
        vectors++; if (bus.sum !== 10'd65 || bus.err !== 10'd5) begin miscompares++; $display("FAIL stagger sum/err got %0d/%0d exp 65/5", bus.sum, bus.err); end
        tick();
    endtask

    task automatic test_overrun();
        set_in(1, 10, 0, 0, 0);
        tick();
        set_in(1, 99, 0, 0, 0);
        tick();
        set_in(0, 0, 1, 5, 15);
        tick();
        set_in(0, 0, 0, 0, 0);
        vectors++; if (bus.sum_valid !== 1'b1 || bus.sum !== 10'd15) begin miscompares++; $display("FAIL overrun sum got %0b/%0d exp 1/15", bus.sum_valid, bus.sum); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun sticky cyc %0d got %0b exp 1", i, bus.overrun); end
            tick();
        end
    endtask

    task automatic test_window();
        rst = 1; tick(); rst = 0;
        do_sample(10, 20, 33);
        do_sample(5, 5, 10);
        do_sample(30, 30, 53);
        do_sample(1, 1, 4);
        vectors++; if (bus.mae_valid !== 1'b1) begin miscompares++; $display("FAIL window mae_valid got %0b exp 1", bus.mae_valid); end
        vectors++; if (bus.mae_sum !== 20'd12) begin miscompares++; $display("FAIL window mae_sum got %0d exp 12", bus.mae_sum); end
        vectors++; if (bus.sample_cnt !== 10'd0) begin miscompares++; $display("FAIL window sample_cnt got %0d exp 0", bus.sample_cnt); end
        tick();
        vectors++; if (bus.mae_valid !== 1'b0 || bus.mae_sum !== 20'd12) begin miscompares++; $display("FAIL window hold got %0b/%0d exp 0/12", bus.mae_valid, bus.mae_sum); end
        do_sample(50, 50, 94);
        vectors++; if (bus.sample_cnt !== 10'd1) begin miscompares++; $display("FAIL window restart_cnt got %0d exp 1", bus.sample_cnt); end
        for (int i = 0; i < 3; i++) do_sample(7, 8, 16);
        vectors++; if (bus.mae_valid !== 1'b1 || bus.mae_sum !== 20'd9) begin miscompares++; $display("FAIL window second got %0b/%0d exp 1/9", bus.mae_valid, bus.mae_sum); end
    endtask

    task automatic test_reset_mid();
        do_sample(20, 20, 45);
        do_sample(20, 20, 35);
        set_in(1, 100, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        rst = 1; tick(); rst = 0;
        vectors++; if (bus.sample_cnt !== 10'd0 || bus.mae_sum !== '0 || bus.mae_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid acc got cnt %0d mae %0d/%0b exp 0/0/0", bus.sample_cnt, bus.mae_sum, bus.mae_valid); end
        vectors++; if (bus.sum !== '0 || bus.err !== '0 || bus.sum_valid !== 1'b0 || bus.overrun !== 1'b0) begin miscompares++; $display("FAIL rstmid outs got sum %0d err %0d v %0b ovr %0b exp zeros", bus.sum, bus.err, bus.sum_valid, bus.overrun); end
        set_in(0, 0, 1, 3, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        tick();
        vectors++; if (bus.sum_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid stale_join got %0b exp 0", bus.sum_valid); end
        set_in(1, 2, 0, 0, 6);
        tick();
        set_in(0, 0, 0, 0, 0);
        vectors++; if (bus.sum_valid !== 1'b1 || bus.sum !== 10'd5 || bus.err !== 10'd1) begin miscompares++; $display("FAIL rstmid fresh_pair got %0b/%0d/%0d exp 1/5/1", bus.sum_valid, bus.sum, bus.err); end
        tick();
        for (int i = 0; i < 3; i++) do_sample(3, 4, 8);
        vectors++; if (bus.mae_valid !== 1'b1 || bus.mae_sum !== 20'd4) begin miscompares++; $display("FAIL rstmid mae got %0b/%0d exp 1/4", bus.mae_valid, bus.mae_sum); end
    endtask

    task automatic test_join_capture();
        set_in(1, 20, 0, 0, 0);
        tick();
        set_in(0, 0, 1, 30, 50);
        tick();
        set_in(0, 0, 1, 7, 0);
        vectors++; if (bus.sum_valid !== 1'b1 || bus.sum !== 10'd50) begin miscompares++; $display("FAIL joincap first got %0b/%0d exp 1/50", bus.sum_valid, bus.sum); end
        tick();
        set_in(1, 8, 0, 0, 10);
        vectors++; if (bus.sum_valid !== 1'b0 || bus.overrun !== 1'b0) begin miscompares++; $display("FAIL joincap capture got v %0b ovr %0b exp 0/0", bus.sum_valid, bus.overrun); end
        tick();
        set_in(0, 0, 0, 0, 0);
        vectors++; if (bus.sum_valid !== 1'b1 || bus.sum !== 10'd15 || bus.err !== 10'd5 || bus.overrun !== 1'b0) begin miscompares++; $display("FAIL joincap pair got v %0b sum %0d err %0d ovr %0b exp 1/15/5/0", bus.sum_valid, bus.sum, bus.err, bus.overrun); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) set_in(1, (i * 37) % 512, 0, 0, 0);
            else            set_in(0, 0, 1, (i * 53) % 512, (i * 91) % 1024);
            tick();
            vectors++; if (bus.sum_valid !== e_sv || bus.next_req !== e_sv) begin miscompares++; $display("FAIL b2b valid cyc %0d got %0b/%0b exp %0b", i, bus.sum_valid, bus.next_req, e_sv); end
            if (e_sv) begin
                vectors++; if (bus.sum !== 10'(e_sum) || bus.err !== 10'(e_err)) begin miscompares++; $display("FAIL b2b sum/err cyc %0d got %0d/%0d exp %0d/%0d", i, bus.sum, bus.err, e_sum, e_err); end
            end
            vectors++; if (bus.sample_cnt !== 10'(e_cnt) || bus.mae_valid !== e_mv) begin miscompares++; $display("FAIL b2b acc cyc %0d got cnt %0d mv %0b exp %0d/%0b", i, bus.sample_cnt, bus.mae_valid, e_cnt, e_mv); end
        end
        set_in(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 99) < 45), $urandom_range(0, 511),
                   ($urandom_range(0, 99) < 45), $urandom_range(0, 511),
                   $urandom_range(0, 1023));
            tick();
            vectors++; if (bus.sum_valid !== e_sv || bus.next_req !== e_sv) begin miscompares++; $display("FAIL rnd valid cyc %0d got %0b/%0b exp %0b", i, bus.sum_valid, bus.next_req, e_sv); end
            if (e_sv) begin
                vectors++; if (bus.sum !== 10'(e_sum) || bus.err !== 10'(e_err)) begin miscompares++; $display("FAIL rnd sum/err cyc %0d got %0d/%0d exp %0d/%0d", i, bus.sum, bus.err, e_sum, e_err); end
            end
            vectors++; if (bus.sample_cnt !== 10'(e_cnt) || bus.mae_valid !== e_mv) begin miscompares++; $display("FAIL rnd acc cyc %0d got cnt %0d mv %0b exp %0d/%0b", i, bus.sample_cnt, bus.mae_valid, e_cnt, e_mv); end
            vectors++; if (bus.mae_sum !== 20'(e_mae)) begin miscompares++; $display("FAIL rnd mae_sum cyc %0d got %0d exp %0d", i, bus.mae_sum, e_mae); end
            vectors++; if (bus.overrun !== m_ovr) begin miscompares++; $display("FAIL rnd overrun cyc %0d got %0b exp %0b", i, bus.overrun, m_ovr); end
            if (i == 300) begin
                rst = 1; tick(); rst = 0;
                vectors++; if (bus.overrun !== 1'b0 || bus.sample_cnt !== 10'd0) begin miscompares++; $display("FAIL rnd reset got ovr %0b cnt %0d exp 0/0", bus.overrun, bus.sample_cnt); end
            end
        end
        set_in(0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0);
        test_reset();
        test_both_same();
        test_staggered();
        test_overrun();
        test_window();
        test_reset_mid();
        test_join_capture();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dot_result_join.md
# dot_result_join

Downstream stage of the 4-term Q0.6 dot-product core. Captures the two independently completing half-results (`result1` = num1·num2 + num3·num4, `result2` = num5·num6 + num7·num8, each already scaled by 1/64), joins them into one sum and requests the next operand set. It also measures hardware accuracy on-chip: absolute error against a supplied ideal value, accumulated over a fixed window of samples.

## Interface
- `W_HALF`, 9: width of each half-result.
- `W_SUM`, 10: width of joined sum, ideal value and error.
- `WINDOW`, 1000: samples per accuracy window, legal range 1..1024.
- `W_ACC`, 20: width of error accumulator.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en_out1` in 1: single-cycle pulse, `result1` valid this cycle.
- `result1` in W_HALF: first half-result, unsigned.
- `en_out2` in 1: single-cycle pulse, `result2` valid this cycle.
- `result2` in W_HALF: second half-result, unsigned.
- `ideal` in W_SUM: exact reference for the current sample, sampled on the join cycle.
- `sum_valid` out 1: one-cycle pulse, `sum`/`err` valid.
- `sum` out W_SUM: result1 + result2, zero-extended.
- `err` out W_SUM: |sum − ideal|.
- `next_req` out 1: one-cycle pulse to upstream, equal to `sum_valid`; drives the core's `en_in`.
- `mae_valid` out 1: one-cycle pulse at window close.
- `mae_sum` out W_ACC: total absolute error of the closed window, held until next close.
- `sample_cnt` out 10: samples accumulated in the current window.
- `overrun` out 1: sticky, a half arrived while its slot was already full.

## Operation
- Two holding slots (value + full flag), one per half. FSM states: EMPTY, HAVE1, HAVE2, JOIN.
- EMPTY: `en_out1` only → HAVE1; `en_out2` only → HAVE2; both same cycle → JOIN with both captured.
- HAVE1: `en_out2` → JOIN; `en_out1` again → stay, set `overrun`, keep the original value (new one dropped). HAVE2 symmetric.
- JOIN (one cycle): register sum = slot1 + slot2, err = |sum − ideal| (compare unsigned, subtract smaller from larger), assert `sum_valid`/`next_req`; clear both slots; → EMPTY. A half arriving during JOIN is captured into its freshly cleared slot (no overrun).
- Accumulator: on the cycle after `sum_valid`, acc ← acc + err (saturating at all-ones), `sample_cnt` ← `sample_cnt` + 1.
- When the update makes the count equal WINDOW: `mae_sum` ← acc + err (saturated), `mae_valid` pulses, acc ← 0, `sample_cnt` ← 0 on the same edge.
- `overrun` clears only on `rst`.
- Reset values: all outputs 0, slots empty, acc 0, FSM EMPTY. Reset mid-window discards partial accumulation and any held half.

## Timing
- Second half arrives at cycle T (edge T captures it) → `sum_valid`, `sum`, `err`, `next_req` high during cycle T+1.
- Accumulation/count update visible at T+2; `mae_valid` high during T+2 on window close.
- Back-to-back samples: minimum join interval 2 cycles (JOIN then a fresh capture); the accumulator accepts one sample per cycle, so no stall is ever needed.
- `ideal` must be stable in the cycle before `sum_valid` (the join cycle); not sampled otherwise.
- Width rules: sum of two 9-bit values fits W_SUM; err ≤ 1023; 1024 × 1023 < 2^20, so saturation occurs only with illegal parameters, but it is still implemented.

## Test plan
- Both halves same cycle: result1=62, result2=62, ideal=124 → one cycle later sum=124, err=0, `sum_valid`=`next_req`=1 for exactly one cycle.
- Staggered: result1=40 at T, result2=25 at T+3, ideal=70 → sum=65, err=5 at T+4; nothing asserted at T+1..T+3.
- Overrun: `en_out1` with 10, then `en_out1` with 99, then `en_out2` with 5 → sum=15, `overrun`=1 and stays 1 until `rst`.
- Window close with WINDOW=4: errors 3, 0, 7, 2 → `mae_valid` pulse with `mae_sum`=12, `sample_cnt` back to 0, next sample starts from acc=0.
- Reset mid-window: 2 samples (err 5 each), HAVE1 pending, assert `rst` one cycle → all outputs 0, no `sum_valid` from stale half; next window of 4 errors of 1 gives `mae_sum`=4.
- Half during JOIN: result2 re-arrives in the JOIN cycle → captured, no overrun; pairs correctly with the following `en_out1`.
